// File: rtl/tb_pkg.sv
// Shared types and constants for the traceback-memory writer: relative-position codes,
// sizing parameters and the writer state encoding.
package tb_pkg;

   localparam int B     = 4;
   localparam int L     = 8;
   localparam int DEPTH = 2*L - B;
   localparam int CNT_W = 4;
   localparam int AW    = 4;

   localparam logic [2:0] REL_GAP_R_LEFT = 3'd1;
   localparam logic [2:0] REL_GAP_Q_UP   = 3'd2;
   localparam logic [2:0] REL_DIAG_NB    = 3'd3;
   localparam logic [2:0] REL_DIAG_SELF  = 3'd4;
   localparam logic [2:0] REL_GAP_R_SELF = 3'd5;
   localparam logic [2:0] REL_GAP_Q_NB   = 3'd6;
   localparam logic [2:0] REL_NULL       = 3'd7;
   localparam logic [2:0] BASE_GAP       = 3'b100;

   typedef enum logic [1:0] {
      TBW_IDLE = 2'd0,
      TBW_FILL = 2'd1,
      TBW_FULL = 2'd2
   } tbw_state_t;

endpackage

// File: rtl/tb_mem_writer_bank.sv
// One traceback bank: DEPTH x 3-bit flops, single-cycle write, zero-latency read.
// No backpressure; out-of-range reads return the null code.
module tb_bank
   import tb_pkg::*;
#(
   parameter int DEPTH_P = DEPTH
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [2:0]    wdata,
   input  logic [7:0]    raddr,
   output logic [2:0]    rdata
);

   logic [2:0] mem [DEPTH_P];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH_P; i++) mem[i] <= REL_NULL;
      end else if (clr) begin
         for (int i = 0; i < DEPTH_P; i++) mem[i] <= REL_NULL;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Index only once the address is known to be in range.
   always_comb begin
      rdata = REL_NULL;
      if (raddr < 8'(DEPTH_P)) rdata = mem[raddr[AW-1:0]];
   end

endmodule

// File: rtl/tb_mem_writer.sv
// Traceback-memory writer: one bank per PE, per-PE write counters, done when all banks full.
// Write takes effect at the next edge, read is combinational; excess writes are dropped and flagged.
module tb_mem_writer
   import tb_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [B-1:0]     pe_valid,
   input  logic [3*B-1:0]   pe_rel_pos,
   input  logic [1:0]       rd_pe_id,
   input  logic [7:0]       rd_addr,
   output logic [7:0]       rd_rel_pos,
   output logic [CNT_W*B-1:0] wr_cnt,
   output logic             done,
   output logic             err
);

   tbw_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt [B];
   logic [B-1:0]     we;
   logic [B-1:0]     drop;
   logic [B-1:0]     bank_full_nxt;
   logic             all_full_nxt;
   logic [2:0]       bank_rd [B];

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   // start wins over any write presented in the same cycle.
   always_comb begin
      we            = '0;
      drop          = '0;
      bank_full_nxt = '0;
      for (int i = 0; i < B; i++) begin
         if (!start && pe_valid[i]) begin
            if (state == TBW_FILL && cnt[i] < DEPTH_C) we[i] = 1'b1;
            else                                        drop[i] = 1'b1;
         end
         bank_full_nxt[i] = (cnt[i] == DEPTH_C) ||
                            (we[i] && (cnt[i] == DEPTH_C - CNT_W'(1)));
      end
      all_full_nxt = &bank_full_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = TBW_FILL;
      end else begin
         case (state)
            TBW_IDLE: state_nxt = TBW_IDLE;
            TBW_FILL: if (all_full_nxt) state_nxt = TBW_FULL;
            TBW_FULL: state_nxt = TBW_FULL;
            default:  state_nxt = TBW_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= TBW_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < B; i++) cnt[i] <= '0;
         done <= 1'b0;
         err  <= 1'b0;
      end else if (start) begin
         for (int i = 0; i < B; i++) cnt[i] <= '0;
         done <= 1'b0;
         err  <= 1'b0;
      end else begin
         for (int i = 0; i < B; i++) begin
            if (we[i]) cnt[i] <= cnt[i] + CNT_W'(1);
         end
         if (state == TBW_FILL && all_full_nxt) done <= 1'b1;
         if (|drop) err <= 1'b1;
      end
   end

   for (genvar g = 0; g < B; g++) begin : g_bank
      tb_bank #(.DEPTH_P(DEPTH)) u_bank (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (start),
         .we    (we[g]),
         .waddr (cnt[g]),
         .wdata (pe_rel_pos[3*g +: 3]),
         .raddr (rd_addr),
         .rdata (bank_rd[g])
      );
   end

   always_comb begin
      rd_rel_pos = {5'b0, REL_NULL};
      if ({1'b0, rd_pe_id} < 3'(B)) rd_rel_pos = {5'b0, bank_rd[rd_pe_id]};
   end

   always_comb begin
      wr_cnt = '0;
      for (int i = 0; i < B; i++) wr_cnt[CNT_W*i +: CNT_W] = cnt[i];
   end

endmodule
